// File: rtl/point_scalar_mult_ct_pkg.sv
// Shared defaults, state encoding and trit helper for the GF(3^97) scalar multiplier.
package point_scalar_mult_ct_pkg;

    localparam int W_DEF  = 194;
    localparam int SB_DEF = 152;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DBL  = 3'd2,
        ST_ADD  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // Trits are stored {hi,lo}: 00 = 0, 01 = 1, 10 = 2, so negation just swaps the pair.
    function automatic logic [1:0] trit_neg(input logic [1:0] t);
        return {t[0], t[1]};
    endfunction

endpackage

// File: rtl/point_scalar_mult_ct_if.sv
// Request/result bus of the scalar multiplier plus the operand/result bus to the point adder.
interface point_scalar_mult_ct_if import point_scalar_mult_ct_pkg::*; #(
    parameter int W  = W_DEF,
    parameter int SB = SB_DEF
);
    logic          start;
    logic [W-1:0]  x1;
    logic [W-1:0]  y1;
    logic          zero1;
    logic [SB-1:0] c;
    logic          neg;
    logic          ready;
    logic          done;
    logic [W-1:0]  x3;
    logic [W-1:0]  y3;
    logic          zero3;
    logic          err;

    logic          add_restart;
    logic [W-1:0]  add_ax;
    logic [W-1:0]  add_ay;
    logic          add_az;
    logic [W-1:0]  add_bx;
    logic [W-1:0]  add_by;
    logic          add_bz;
    logic          add_done;
    logic [W-1:0]  add_rx;
    logic [W-1:0]  add_ry;
    logic          add_rz;

    modport master (
        output start, x1, y1, zero1, c, neg,
        input  ready, done, x3, y3, zero3, err
    );

    modport slave (
        input  start, x1, y1, zero1, c, neg,
        output ready, done, x3, y3, zero3, err,
        output add_restart, add_ax, add_ay, add_az, add_bx, add_by, add_bz,
        input  add_done, add_rx, add_ry, add_rz
    );

    modport adder (
        input  add_restart, add_ax, add_ay, add_az, add_bx, add_by, add_bz,
        output add_done, add_rx, add_ry, add_rz
    );

endinterface

// File: rtl/point_scalar_mult_ct_add_phase_ctl.sv
// Add-phase sequencer: one kick cycle, then either wait for the adder or run a fixed window.
module add_phase_ctl #(
    parameter bit CONST_TIME = 1'b1,
    parameter int ADD_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic add_done,
    output logic kick,
    output logic phase_end,
    output logic err_set
);
    localparam int CW = $clog2(ADD_CYCLES + 1);

    logic          busy_r;
    logic [CW-1:0] cnt_r;
    logic          window_end_s;

    // Kick, phase end and overrun decode; the adder's done is ignored in the kick cycle.
    always_comb begin
        kick         = active & ~busy_r;
        window_end_s = (cnt_r == CW'(ADD_CYCLES));
        if (CONST_TIME) begin
            phase_end = busy_r & window_end_s;
            err_set   = busy_r & window_end_s & ~add_done;
        end else begin
            phase_end = busy_r & add_done;
            err_set   = 1'b0;
        end
    end

    // Busy flag and cycles-since-kick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (phase_end) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (kick) begin
            busy_r <= 1'b1;
            cnt_r  <= CW'(1);
        end else if (busy_r) begin
            cnt_r  <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/point_scalar_mult_ct.sv
// MSB-first double-and-add scalar multiplier over a shared external point adder,
// with an optional constant-time schedule (fixed-length add phases, add on every bit).
module point_scalar_mult_ct import point_scalar_mult_ct_pkg::*; #(
    parameter int W          = W_DEF,
    parameter int SB         = SB_DEF,
    parameter bit CONST_TIME = 1'b1,
    parameter int ADD_CYCLES = 1024
) (
    input logic clk,
    input logic reset,
    point_scalar_mult_ct_if.slave bus
);
    localparam int BW = $clog2(SB + 1);

    state_t        state_r, state_s;
    logic [W-1:0]  px_r, py_r, ax_r, ay_r, x3_r, y3_r, y1_neg_s;
    logic          pz_r, az_r, zero3_r;
    logic [SB-1:0] k_r;
    logic [BW-1:0] bits_r;
    logic          ready_r, done_r, err_r;
    logic          active_s, accept_s, kick_s, phase_end_s, err_set_s;

    add_phase_ctl #(
        .CONST_TIME (CONST_TIME),
        .ADD_CYCLES (ADD_CYCLES)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .active    (active_s),
        .add_done  (bus.add_done),
        .kick      (kick_s),
        .phase_end (phase_end_s),
        .err_set   (err_set_s)
    );

    assign active_s        = (state_r == ST_DBL) || (state_r == ST_ADD);
    assign accept_s        = (state_r == ST_IDLE) && bus.start;
    assign bus.add_restart = ~reset | kick_s;
    assign bus.add_ax      = ax_r;
    assign bus.add_ay      = ay_r;
    assign bus.add_az      = az_r;
    assign bus.add_bx      = (state_r == ST_ADD) ? px_r : ax_r;
    assign bus.add_by      = (state_r == ST_ADD) ? py_r : ay_r;
    assign bus.add_bz      = (state_r == ST_ADD) ? pz_r : az_r;
    assign bus.ready       = ready_r;
    assign bus.done        = done_r;
    assign bus.x3          = x3_r;
    assign bus.y3          = y3_r;
    assign bus.zero3       = zero3_r;
    assign bus.err         = err_r;

    // Field negation of y1, trit by trit.
    always_comb begin
        y1_neg_s = {W{1'b0}};
        for (int i = 0; i < W / 2; i++) begin
            y1_neg_s[2*i +: 2] = trit_neg(bus.y1[2*i +: 2]);
        end
    end

    // Next-state decode; in constant-time mode a 0-bit still runs a (discarded) add.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (bus.start) state_s = ST_LOAD; else state_s = ST_IDLE;
            ST_LOAD: state_s = ST_DBL;
            ST_DBL: begin
                if (phase_end_s) begin
                    if (!CONST_TIME && !k_r[SB-1]) state_s = ST_NEXT;
                    else                           state_s = ST_ADD;
                end else begin
                    state_s = ST_DBL;
                end
            end
            ST_ADD:  if (phase_end_s) state_s = ST_NEXT; else state_s = ST_ADD;
            ST_NEXT: if (bits_r > BW'(1)) state_s = ST_DBL; else state_s = ST_FIN;
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with ready/done registered from the next state; err is sticky per job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_IDLE);
            done_r  <= (state_s == ST_FIN);
            if (accept_s)       err_r <= 1'b0;
            else if (err_set_s) err_r <= 1'b1;
        end
    end

    // Base point, scalar, bit counter and accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_r   <= {W{1'b0}};
            py_r   <= {W{1'b0}};
            pz_r   <= 1'b1;
            k_r    <= {SB{1'b0}};
            bits_r <= {BW{1'b0}};
            ax_r   <= {W{1'b0}};
            ay_r   <= {W{1'b0}};
            az_r   <= 1'b1;
        end else if (accept_s) begin
            px_r   <= bus.x1;
            py_r   <= bus.neg ? y1_neg_s : bus.y1;
            pz_r   <= bus.zero1;
            k_r    <= bus.c;
            bits_r <= BW'(SB);
            ax_r   <= {W{1'b0}};
            ay_r   <= {W{1'b0}};
            az_r   <= 1'b1;
        end else if (phase_end_s && ((state_r == ST_DBL) || k_r[SB-1])) begin
            ax_r   <= bus.add_rx;
            ay_r   <= bus.add_ry;
            az_r   <= bus.add_rz;
        end else if (state_r == ST_NEXT) begin
            k_r    <= {k_r[SB-2:0], 1'b0};
            bits_r <= bits_r - BW'(1);
        end
    end

    // Result registers load on entry to FIN; infinity always reads as zero coordinates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x3_r    <= {W{1'b0}};
            y3_r    <= {W{1'b0}};
            zero3_r <= 1'b1;
        end else if (state_s == ST_FIN) begin
            x3_r    <= az_r ? {W{1'b0}} : ax_r;
            y3_r    <= az_r ? {W{1'b0}} : ay_r;
            zero3_r <= az_r;
        end
    end

endmodule

// File: tb/tb_point_scalar_mult_ct.sv
// Bench for point_scalar_mult_ct: a point-adder model over the GF(3) subfield of the curve,
// a repeated-addition scoreboard for expected results and an absolute check of done timing.
module tb_point_scalar_mult_ct;
    localparam int W        = 194;
    localparam int SB       = 8;
    localparam int A        = 6;
    localparam int DONE_OFS = 1 + 2 * SB * (A + 1) + SB;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         z;
    } pt_t;

    typedef struct {
        pt_t  p;
        logic err;
        bit   chk_pt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0, t_acc = 0, errors = 0, checks = 0, lat_full = 5, op_lat;
    exp_t sb_q[$];

    point_scalar_mult_ct_if #(.W(W), .SB(SB)) bus ();

    point_scalar_mult_ct #(
        .W(W), .SB(SB), .CONST_TIME(1'b1), .ADD_CYCLES(A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int m3(int v);
        return ((v % 3) + 3) % 3;
    endfunction

    function automatic int t2i(logic [W-1:0] v);
        if (v[1:0] == 2'b01) return 1;
        if (v[1:0] == 2'b10) return 2;
        return 0;
    endfunction

    function automatic logic [W-1:0] i2t(int v);
        logic [W-1:0] r;
        r = '0;
        if (m3(v) == 1)      r[1:0] = 2'b01;
        else if (m3(v) == 2) r[1:0] = 2'b10;
        return r;
    endfunction

    function automatic pt_t inf_pt();
        pt_t r;
        r.x = '0; r.y = '0; r.z = 1'b1;
        return r;
    endfunction

    // Affine addition on y^2 = x^3 - x + 1 over GF(3); there 1/v == v for nonzero v.
    function automatic pt_t padd(pt_t a, pt_t b);
        int ax, ay, bx, by, lam, x3, y3;
        pt_t r;
        if (a.z && b.z) return inf_pt();
        if (a.z) return b;
        if (b.z) return a;
        ax = t2i(a.x); ay = t2i(a.y); bx = t2i(b.x); by = t2i(b.y);
        if (ax == bx && m3(ay + by) == 0) return inf_pt();
        if (ax == bx) begin
            lam = ay;
            x3  = m3(lam * lam + ax);
            y3  = m3(-(lam * lam * lam + ay));
        end else begin
            lam = m3((by - ay) * (bx - ax));
            x3  = m3(lam * lam - ax - bx);
            y3  = m3(lam * (ax - x3) - ay);
        end
        r.x = i2t(x3); r.y = i2t(y3); r.z = 1'b0;
        return r;
    endfunction

    function automatic pt_t smul(int k, pt_t p);
        pt_t acc;
        acc = inf_pt();
        for (int i = 0; i < k; i++) acc = padd(acc, p);
        return acc;
    endfunction

    function automatic pt_t negp(pt_t p);
        pt_t r;
        r = p;
        r.y = i2t(-t2i(p.y));
        return r;
    endfunction

    function automatic logic [W-1:0] negfull(logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < W; i += 2) begin
            r[i]     = v[i+1];
            r[i+1]   = v[i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Point adder model: result computed at restart, done after op_lat cycles (short for infinity).
    pt_t  op_a, op_b;
    pt_t  m_r    = '0;
    logic m_done = 1'b0;
    int   m_cnt  = 0;
    assign op_a         = {bus.add_ax, bus.add_ay, bus.add_az};
    assign op_b         = {bus.add_bx, bus.add_by, bus.add_bz};
    assign op_lat       = (op_a.z || op_b.z) ? 2 : lat_full;
    assign bus.add_rx   = m_r.x;
    assign bus.add_ry   = m_r.y;
    assign bus.add_rz   = m_r.z;
    assign bus.add_done = m_done;

    always @(posedge clk) begin
        if (bus.add_restart) begin
            m_r    <= padd(op_a, op_b);
            m_cnt  <= op_lat - 1;
            m_done <= (op_lat == 1);
        end else if (m_cnt > 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int cval, input pt_t p, input logic n,
                         input pt_t expp, input logic experr, input bit chk_pt);
        exp_t e;
        @(negedge clk);
        bus.x1 = p.x; bus.y1 = p.y; bus.zero1 = p.z;
        bus.c = SB'(cval); bus.neg = n; bus.start = 1'b1;
        e.p = expp; e.err = experr; e.chk_pt = chk_pt;
        sb_q.push_back(e);
        @(posedge clk); #1;
        t_acc = cyc;
        bus.start = 1'b0;
        chk("accept_ready", W'(bus.ready), W'(1'b0));
        chk("accept_err", W'(bus.err), W'(1'b0));
    endtask

    task automatic collect(input string tag);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk({tag, "_done_seen"}, W'(seen), W'(1'b1));
        chk({tag, "_done_cycle"}, W'(cyc - t_acc), W'(DONE_OFS));
        e = sb_q.pop_front();
        if (e.chk_pt) begin
            chk({tag, "_x3"}, bus.x3, e.p.x);
            chk({tag, "_y3"}, bus.y3, e.p.y);
            chk({tag, "_zero3"}, W'(bus.zero3), W'(e.p.z));
        end
        chk({tag, "_err"}, W'(bus.err), W'(e.err));
        @(negedge clk);
        chk({tag, "_done_pulse"}, W'(bus.done), W'(1'b0));
        chk({tag, "_ready_back"}, W'(bus.ready), W'(1'b1));
    endtask

    initial begin
        pt_t  p0, pb, pn, pr;
        exp_t dropped;
        int   cv, mk;
        logic nv;
        logic [W-1:0] rx, ry;

        bus.start = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.zero1 = 1'b0; bus.c = '0; bus.neg = 1'b0;
        p0.x = i2t(0); p0.y = i2t(1); p0.z = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", W'(bus.ready), W'(1'b1));
        chk("rst_done", W'(bus.done), W'(1'b0));
        chk("rst_x3", bus.x3, '0);
        chk("rst_y3", bus.y3, '0);
        chk("rst_zero3", W'(bus.zero3), W'(1'b1));
        chk("rst_err", W'(bus.err), W'(1'b0));
        reset = 1'b1;

        drive(1, p0, 1'b0, p0, 1'b0, 1'b1);                 collect("c1");
        drive(0, p0, 1'b0, inf_pt(), 1'b0, 1'b1);           collect("c0");
        pb.x = i2t(1); pb.y = i2t(1); pb.z = 1'b1;
        drive(5, pb, 1'b0, inf_pt(), 1'b0, 1'b1);           collect("zero1");

        rx = rand_w(); ry = rand_w();
        pb.x = rx; pb.y = ry; pb.z = 1'b0;
        pr.x = rx; pr.y = negfull(ry); pr.z = 1'b0;
        drive(1, pb, 1'b1, pr, 1'b0, 1'b1);                 collect("c1_neg");
        drive(3, p0, 1'b0, smul(3, p0), 1'b0, 1'b1);        collect("c3");
        drive(255, p0, 1'b0, smul(255, p0), 1'b0, 1'b1);    collect("cff");

        for (int i = 0; i < 4; i++) begin
            cv = int'($urandom_range(0, 255));
            mk = int'($urandom_range(1, 6));
            nv = 1'($urandom_range(0, 1));
            pb = smul(mk, p0);
            pn = nv ? negp(pb) : pb;
            drive(cv, pb, nv, smul(cv, pn), 1'b0, 1'b1);    collect("rand");
        end

        // Adder slower than the fixed window: err must be raised, done still pulses once.
        lat_full = A + 2;
        drive(255, p0, 1'b0, inf_pt(), 1'b1, 1'b0);         collect("overrun");
        lat_full = 5;
        drive(2, p0, 1'b0, smul(2, p0), 1'b0, 1'b1);        collect("err_clear");

        // Abort in the first ADD phase (cycles +8..+14 after accept).
        drive(8'hA5, p0, 1'b0, smul(165, p0), 1'b0, 1'b1);
        while (cyc < t_acc + 10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", W'(bus.ready), W'(1'b1));
        chk("abort_zero3", W'(bus.zero3), W'(1'b1));
        chk("abort_done", W'(bus.done), W'(1'b0));
        chk("abort_x3", bus.x3, '0);
        dropped = sb_q.pop_back();
        @(negedge clk);
        reset = 1'b1;
        drive(5, p0, 1'b1, smul(5, negp(p0)), 1'b0, 1'b1);  collect("after_abort");

        chk("scoreboard_empty", W'(sb_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
